// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM states for the iterative ALU
//
// Purpose: op-code enum (OP_SLL .. OP_DIV, OP_RESERVED) and the controller
//          state enum used by alu_iter and its testbench.
// Ports:   none (package).

package alu_pkg;

    typedef enum logic [3:0] {
        OP_SLL      = 4'd0,
        OP_SRA      = 4'd1,
        OP_SRL      = 4'd2,
        OP_MULTU    = 4'd3,
        OP_DIVU     = 4'd4,
        OP_ADD      = 4'd5,
        OP_SUB      = 4'd6,
        OP_AND      = 4'd7,
        OP_OR       = 4'd8,
        OP_XOR      = 4'd9,
        OP_NOR      = 4'd10,
        OP_SLT      = 4'd11,
        OP_SLTU     = 4'd12,
        OP_MULT     = 4'd13,
        OP_DIV      = 4'd14,
        OP_RESERVED = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - iterative shift-add multiplier / restoring divider
//
// Purpose: one-bit-per-cycle multiply and divide on operand magnitudes, with
//          combinational sign correction of the final registers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_start           load operands (one cycle)
//   i_step            perform one iteration this cycle
//   i_is_div          1 = divide, 0 = multiply
//   i_is_signed       operands are two's complement
//   i_a, i_b          operands
//   o_last            the current step is the final (WIDTH-th) iteration
//   o_res1, o_res2    HI/LO or quotient/remainder, sign-corrected
//   o_div_zero        divide had a zero divisor

module alu_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_res1,
    output logic [WIDTH-1:0] o_res2,
    output logic             o_div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // r_acc: product high half / partial remainder.
    // r_lo:  multiplier being shifted out / dividend shifted out, quotient in.
    // r_m:   multiplicand (mul) or divisor (div), held for the whole op.
    logic [WIDTH-1:0] r_acc, r_lo, r_m, r_a_raw;
    logic             r_is_div, r_neg_q, r_neg_r, r_div_zero;
    logic [CNT_W-1:0] r_cnt;

    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_sum, w_shift, w_diff;
    logic             w_div_ok;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_q, w_r;

    assign w_a_neg = i_is_signed & i_a[WIDTH-1];
    assign w_b_neg = i_is_signed & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    assign w_sum    = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_shift  = {r_acc, r_lo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_m};
    assign w_div_ok = ~w_diff[WIDTH];

    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_lo       <= '0;
            r_m        <= '0;
            r_a_raw    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
        end else if (i_start) begin
            r_is_div   <= i_is_div;
            r_acc      <= '0;
            r_lo       <= i_is_div ? w_a_mag : w_b_mag;
            r_m        <= i_is_div ? w_b_mag : w_a_mag;
            r_a_raw    <= i_a;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= i_is_div && (i_b == '0);
            r_cnt      <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                r_acc <= w_div_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_lo  <= {r_lo[WIDTH-2:0], w_div_ok};
            end else begin
                // Carry of the add drops into the top of the shifted pair.
                {r_acc, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end
        end
    end

    assign w_prod     = {r_acc, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_q        = r_neg_q ? -r_lo : r_lo;
    assign w_r        = r_neg_r ? -r_acc : r_acc;

    // MIN / -1 needs no special case: |MIN| is MIN unsigned, and negating
    // the MIN quotient wraps back to MIN.
    always_comb begin
        o_res1     = w_prod_fix[2*WIDTH-1:WIDTH];
        o_res2     = w_prod_fix[WIDTH-1:0];
        o_div_zero = 1'b0;
        if (r_is_div) begin
            if (r_div_zero) begin
                o_res1     = '1;
                o_res2     = r_a_raw;
                o_div_zero = 1'b1;
            end else begin
                o_res1 = w_q;
                o_res2 = w_r;
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle EX-stage ALU with valid/ready handshakes
//
// Purpose: single-cycle shift/add/logic/compare ops plus iterative
//          MULT/MULTU/DIV/DIVU via alu_muldiv_core.
// Optional: ALU_OVF_DETECT_EN adds port ovf (signed ADD/SUB overflow flag).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake (op, a, b, shamt)
//   out_valid / out_ready  result handshake
//   result1, result2       primary / secondary result
//   equal                  a == b of the accepted request
//   div_zero               divide by zero flag
//   busy                   controller not idle
//   ovf                    (optional) signed overflow of ADD/SUB

module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result1,
    output logic [WIDTH-1:0]   result2,
    output logic               equal,
    output logic               div_zero,
    output logic               busy
`ifdef ALU_OVF_DETECT_EN
    ,
    output logic               ovf
`endif
);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result1, r_result2;
    logic             r_equal, r_div_zero;

    op_e              w_op;
    logic             w_accept, w_long, w_is_div, w_is_signed;
    logic             w_core_step, w_core_last, w_core_dz;
    logic [WIDTH-1:0] w_core_res1, w_core_res2;
    logic [WIDTH-1:0] w_sum, w_diff, w_alu;

    assign w_op        = op_e'(op);
    assign w_is_div    = (w_op == OP_DIVU) || (w_op == OP_DIV);
    assign w_is_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_long      = w_is_div || (w_op == OP_MULTU) || (w_op == OP_MULT);
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_core_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (!w_long)       w_state_nxt = ST_DONE;
                    else if (w_is_div) w_state_nxt = ST_DIV;
                    else               w_state_nxt = ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                w_core_step = 1'b1;
                if (w_core_last) w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_SLL:  w_alu = b << shamt;
            OP_SRA:  w_alu = $signed(b) >>> shamt;
            OP_SRL:  w_alu = b >> shamt;
            OP_ADD:  w_alu = w_sum;
            OP_SUB:  w_alu = w_diff;
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_XOR:  w_alu = a ^ b;
            OP_NOR:  w_alu = ~(a | b);
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_alu = '0;
        endcase
    end

    alu_muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept && w_long),
        .i_step      (w_core_step),
        .i_is_div    (w_is_div),
        .i_is_signed (w_is_signed),
        .i_a         (a),
        .i_b         (b),
        .o_last      (w_core_last),
        .o_res1      (w_core_res1),
        .o_res2      (w_core_res2),
        .o_div_zero  (w_core_dz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result1  <= '0;
            r_result2  <= '0;
            r_equal    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_equal    <= (a == b);
            r_result1  <= w_long ? '0 : w_alu;
            r_result2  <= '0;
            r_div_zero <= 1'b0;
        end else if (r_state == ST_FIX) begin
            r_result1  <= w_core_res1;
            r_result2  <= w_core_res2;
            r_div_zero <= w_core_dz;
        end
    end

    assign result1  = r_result1;
    assign result2  = r_result2;
    assign equal    = r_equal;
    assign div_zero = r_div_zero;

`ifdef ALU_OVF_DETECT_EN
    logic r_ovf, w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        if (w_op == OP_ADD)
            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        else if (w_op == OP_SUB)
            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst)           r_ovf <= 1'b0;
        else if (w_accept) r_ovf <= w_ovf;
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard testbench for alu_iter (WIDTH = 32)

module tb_alu_iter;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        eq;
        logic        dz;
        logic        ovf;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        equal, div_zero, busy;
    logic [3:0]  op;
    logic [31:0] a, b, result1, result2;
    logic [4:0]  shamt;
`ifdef ALU_OVF_DETECT_EN
    logic        ovf;
`endif

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    alu_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result1   (result1),
        .result2   (result2),
        .equal     (equal),
        .div_zero  (div_zero),
        .busy      (busy)
`ifdef ALU_OVF_DETECT_EN
        ,
        .ovf       (ovf)
`endif
    );

    function automatic exp_t mk(input logic [31:0] r1, input logic [31:0] r2,
                                input logic eq, input logic dz, input logic ov, input int lat);
        exp_t e;
        e.r1 = r1; e.r2 = r2; e.eq = eq; e.dz = dz; e.ovf = ov; e.lat = lat;
        return e;
    endfunction

    // Reference model built on 64-bit integer arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic [4:0] s);
        exp_t e;
        longint sx, sy, t;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        e = mk(32'd0, 32'd0, (x == y), 1'b0, 1'b0, 0);
        case (o)
            4'd0:  e.r1 = y << s;
            4'd1:  e.r1 = (y >> s) | (y[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd2:  e.r1 = y >> s;
            4'd3:  begin p = ux * uy; e.r1 = p[63:32]; e.r2 = p[31:0]; e.lat = 33; end
            4'd4:  begin
                e.lat = 33;
                if (y == 0) begin e.r1 = 32'hFFFF_FFFF; e.r2 = x; e.dz = 1'b1; end
                else begin p = ux / uy; e.r1 = p[31:0]; p = ux % uy; e.r2 = p[31:0]; end
            end
            4'd5:  begin t = sx + sy; e.r1 = x + y; e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd6:  begin t = sx - sy; e.r1 = x - y; e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd7:  e.r1 = x & y;
            4'd8:  e.r1 = x | y;
            4'd9:  e.r1 = x ^ y;
            4'd10: e.r1 = ~(x | y);
            4'd11: e.r1 = (sx < sy) ? 32'd1 : 32'd0;
            4'd12: e.r1 = (ux < uy) ? 32'd1 : 32'd0;
            4'd13: begin t = sx * sy; p = longint'(t); e.r1 = p[63:32]; e.r2 = p[31:0]; e.lat = 33; end
            4'd14: begin
                e.lat = 33;
                if (y == 0) begin e.r1 = 32'hFFFF_FFFF; e.r2 = x; e.dz = 1'b1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin e.r1 = x; e.r2 = 32'd0; end
                else begin t = sx / sy; e.r1 = t[31:0]; t = sx % sy; e.r2 = t[31:0]; end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Present a request and return #1 after the accepting edge, then scramble
    // the inputs so any late sampling by the DUT shows up as a wrong result.
    task automatic send(input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s);
        int n;
        @(negedge clk);
        op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        n_total++;
        if (!in_ready) $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    endtask

    // Wait for out_valid, pop the scoreboard and compare; optionally hold
    // out_ready low for `hold` cycles, then release the result.
    task automatic collect(input string tag, input int hold);
        int cyc;
        exp_t e;
        logic ok;
        logic [31:0] s1, s2;
        cyc = 0;
        while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard_empty got out_valid=%b", tag, out_valid);
            return;
        end
        n_pass++;
        e = sb.pop_front();
        n_total++; if (cyc != e.lat) $display("FAIL %s latency got %0d required %0d", tag, cyc, e.lat); else n_pass++;
        n_total++; if (result1 !== e.r1) $display("FAIL %s result1 got %h required %h", tag, result1, e.r1); else n_pass++;
        n_total++; if (result2 !== e.r2) $display("FAIL %s result2 got %h required %h", tag, result2, e.r2); else n_pass++;
        n_total++; if (equal !== e.eq) $display("FAIL %s equal got %b required %b", tag, equal, e.eq); else n_pass++;
        n_total++; if (div_zero !== e.dz) $display("FAIL %s div_zero got %b required %b", tag, div_zero, e.dz); else n_pass++;
`ifdef ALU_OVF_DETECT_EN
        n_total++; if (ovf !== e.ovf) $display("FAIL %s ovf got %b required %b", tag, ovf, e.ovf); else n_pass++;
`endif
        if (hold > 0) begin
            ok = 1'b1; s1 = result1; s2 = result2;
            repeat (hold) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || result1 !== s1 || result2 !== s2) ok = 1'b0;
            end
            n_total++;
            if (!ok) $display("FAIL %s hold_stable out_valid=%b in_ready=%b r1=%h r2=%h required stable", tag, out_valid, in_ready, result1, result2);
            else n_pass++;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL %s release_out_valid got %b required 0", tag, out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL %s release_in_ready got %b required 1", tag, in_ready); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b required 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else n_pass++;
        n_total++; if (result1 !== 32'd0 || result2 !== 32'd0) $display("FAIL reset_results got %h/%h required 0/0", result1, result2); else n_pass++;
        n_total++; if (equal !== 1'b0 || div_zero !== 1'b0) $display("FAIL reset_flags got eq=%b dz=%b required 0/0", equal, div_zero); else n_pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add();
        sb.push_back(mk(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1, 0));
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
        collect("add_ovf", 0);
        sb.push_back(mk(32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 1'b0, 0));
        send(OP_SUB, 32'd3, 32'd5, 5'd0);
        collect("sub", 0);
    endtask

    task automatic test_shift_cmp();
        sb.push_back(mk(32'hF800_0001, 32'd0, 1'b0, 1'b0, 1'b0, 0));
        send(OP_SRA, 32'd0, 32'h8000_0010, 5'd4);
        collect("sra", 0);
        sb.push_back(mk(32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 0));
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        collect("slt", 0);
        sb.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0));
        send(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
        collect("sltu", 0);
        sb.push_back(mk(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0));
        send(OP_RESERVED, 32'h1234_5678, 32'h1234_5678, 5'd3);
        collect("reserved", 0);
    endtask

    task automatic test_mul();
        sb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0, 33));
        send(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
        collect("mult", 0);
        sb.push_back(mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 33));
        send(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        collect("multu", 0);
    endtask

    task automatic test_div();
        sb.push_back(mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33));
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
        collect("div", 0);
        sb.push_back(mk(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1'b0, 33));
        send(OP_DIVU, 32'd5, 32'd0, 5'd0);
        collect("divu_zero", 0);
        sb.push_back(mk(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0, 33));
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        collect("div_min", 0);
    endtask

    task automatic test_backpressure();
        sb.push_back(mk(32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33));
        send(OP_DIVU, 32'd100, 32'd7, 5'd0);
        collect("divu_bp", 10);
    endtask

    task automatic test_reset_abort();
        logic seen;
        send(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL abort_idle got busy=%b in_ready=%b required 0/1", busy, in_ready); else n_pass++;
        n_total++; if (result1 !== 32'd0 || result2 !== 32'd0 || equal !== 1'b0 || div_zero !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL abort_outputs got r1=%h r2=%h eq=%b dz=%b ov=%b required all 0", result1, result2, equal, div_zero, out_valid);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        n_total++; if (seen) $display("FAIL abort_no_output got out_valid=1 required 0"); else n_pass++;
        sb.push_back(mk(32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 0));
        send(OP_ADD, 32'd2, 32'd3, 5'd0);
        collect("add_after_abort", 0);
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] x, y;
        logic [4:0]  s;
        for (int i = 0; i < 24; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) y = x;
            s = 5'($urandom);
            sb.push_back(model(o, x, y, s));
            send(o, x, y, s);
            collect("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift_cmp();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
